// File: rtl/window_buffer_pkg.sv
// Shared constants and helpers for the K x K sliding-window generator and the
// median core that consumes its flattened window bus.
package window_buffer_pkg;

  localparam int BORDER_VALID = 0;
  localparam int BORDER_ZERO  = 1;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

  // Flat element index of window position (r, c); r=0 newest line, c=0 newest pixel.
  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/window_buffer_if.sv
// Pixel-stream in / window-out bundle between the HDMI RX decoder, the window
// buffer and the median core.
interface window_buffer_if #(
  parameter int K      = 5,
  parameter int PIX_W  = 24,
  parameter int ADDR_W = 11
) ();

  logic [PIX_W-1:0]     rx_pixel;
  logic                 rx_dv;
  logic                 rx_hs;
  logic                 rx_vs;
  logic [K*K*PIX_W-1:0] window;
  logic                 win_valid;
  logic [ADDR_W:0]      line_width;
  logic                 ovf;

  modport master (
    output rx_pixel, rx_dv, rx_hs, rx_vs,
    input  window, win_valid, line_width, ovf
  );

  modport slave (
    input  rx_pixel, rx_dv, rx_hs, rx_vs,
    output window, win_valid, line_width, ovf
  );

endinterface

// File: rtl/window_buffer_line_ram.sv
// Simple dual-port line store: one write port, one registered read port.
// A read and a write to the same address return the old contents.
module line_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1 << ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/window_buffer.sv
// K x K sliding-window generator: K-1 cascaded line RAMs feed K row shift
// registers that advance only on accepted pixels, with frame-fill qualification.
module window_buffer
  import window_buffer_pkg::*;
#(
  parameter int K      = 5,
  parameter int PIX_W  = 24,
  parameter int ADDR_W = 11,
  parameter int BORDER = BORDER_VALID
) (
  input  logic          clk,
  input  logic          rst,
  window_buffer_if.slave bus
);

  localparam int RF_W = clog2(K);
  localparam int PX_W = clog2(K + 1);
  localparam logic [ADDR_W:0]    COL_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [RF_W-1:0]    RF_MAX  = RF_W'(K - 1);
  localparam logic [PX_W-1:0]    PX_FULL = PX_W'(K);

  logic                 w_hs_rise;
  logic                 w_vs_rise;
  logic                 w_col_full;
  logic [ADDR_W-1:0]    w_raddr;
  logic [ADDR_W:0]      w_col_adv;
  logic [PX_W-1:0]      w_px_next;
  logic [K*K*PIX_W-1:0] w_window;
  logic [PIX_W-1:0]     w_rd     [K-1];
  logic [PIX_W-1:0]     w_col_in [K];

  logic [PIX_W-1:0]     r_pix;
  logic                 r_dv_d;
  logic                 r_we_d;
  logic                 r_first_d;
  logic [ADDR_W-1:0]    r_addr_d;
  logic [ADDR_W:0]      r_col;
  logic [ADDR_W:0]      r_line_width;
  logic [RF_W-1:0]      r_rows_filled;
  logic [PX_W-1:0]      r_px_in_line;
  logic                 r_hs_prev;
  logic                 r_vs_prev;
  logic                 r_ovf;
  logic                 r_win_valid;

  assign w_hs_rise  = bus.rx_hs & ~r_hs_prev;
  assign w_vs_rise  = bus.rx_vs & ~r_vs_prev;
  assign w_col_full = (r_col == COL_MAX);
  // A pixel arriving with the frame-start edge is column 0 of the new frame.
  assign w_raddr    = w_vs_rise ? '0 : r_col[ADDR_W-1:0];

  always_comb begin
    w_col_adv = r_col;
    if (bus.rx_dv && !w_col_full) w_col_adv = r_col + 1'b1;
  end

  // Stage 0: capture the pixel and remember where (and whether) it gets written.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs_prev <= 1'b0;
      r_vs_prev <= 1'b0;
      r_dv_d    <= 1'b0;
      r_pix     <= '0;
      r_addr_d  <= '0;
      r_we_d    <= 1'b0;
      r_first_d <= 1'b0;
    end else begin
      r_hs_prev <= bus.rx_hs;
      r_vs_prev <= bus.rx_vs;
      r_dv_d    <= bus.rx_dv;
      if (bus.rx_dv) begin
        r_pix     <= bus.rx_pixel;
        r_addr_d  <= w_raddr;
        r_we_d    <= w_vs_rise | ~w_col_full;
        r_first_d <= w_vs_rise | (r_col == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col         <= '0;
      r_rows_filled <= '0;
      r_line_width  <= '0;
      r_ovf         <= 1'b0;
    end else if (w_vs_rise) begin
      r_col         <= {{ADDR_W{1'b0}}, bus.rx_dv};
      r_rows_filled <= '0;
      r_ovf         <= 1'b0;
    end else begin
      if (bus.rx_dv && w_col_full) r_ovf <= 1'b1;
      if (w_hs_rise) begin
        r_line_width <= w_col_adv;
        r_col        <= '0;
        if (w_col_adv != '0 && r_rows_filled != RF_MAX)
          r_rows_filled <= r_rows_filled + 1'b1;
      end else begin
        r_col <= w_col_adv;
      end
    end
  end

  // Stage 1: count pixels shifted into the current line, saturating at K.
  always_comb begin
    w_px_next = r_px_in_line;
    if (r_first_d) w_px_next = PX_W'(1);
    else if (r_px_in_line != PX_FULL) w_px_next = r_px_in_line + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || w_vs_rise) begin
      r_px_in_line <= '0;
      r_win_valid  <= 1'b0;
    end else begin
      r_win_valid <= r_dv_d && (w_px_next == PX_FULL) &&
                     ((BORDER == BORDER_ZERO) || (r_rows_filled == RF_MAX));
      if (r_dv_d) r_px_in_line <= w_px_next;
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < K - 1; gi++) begin : g_line
      logic [PIX_W-1:0] w_wdata;
      if (gi == 0) begin : g_head
        assign w_wdata = r_pix;
      end else begin : g_cascade
        assign w_wdata = w_rd[gi-1];
      end
      line_ram #(
        .DATA_W (PIX_W),
        .ADDR_W (ADDR_W)
      ) u_ram (
        .clk     (clk),
        .i_we    (r_dv_d & r_we_d),
        .i_waddr (r_addr_d),
        .i_wdata (w_wdata),
        .i_re    (bus.rx_dv),
        .i_raddr (w_raddr),
        .o_rdata (w_rd[gi])
      );
    end

    for (gi = 0; gi < K; gi++) begin : g_row
      logic [PIX_W-1:0] r_row [K];
      if (gi == 0) begin : g_newest
        assign w_col_in[gi] = r_pix;
      end else begin : g_older
        // Lines not yet received in this frame read as zero in border mode.
        assign w_col_in[gi] = ((BORDER == BORDER_ZERO) && (RF_W'(gi) > r_rows_filled))
                              ? '0 : w_rd[gi-1];
      end

      always_ff @(posedge clk) begin
        if (rst || w_vs_rise) begin
          for (int c = 0; c < K; c++) r_row[c] <= '0;
        end else if (r_dv_d) begin
          r_row[0] <= w_col_in[gi];
          for (int c = 1; c < K; c++) r_row[c] <= r_row[c-1];
        end
      end

      for (gj = 0; gj < K; gj++) begin : g_col
        assign w_window[win_idx(gi, gj, K)*PIX_W +: PIX_W] = r_row[gj];
      end
    end
  endgenerate

  assign bus.window     = w_window;
  assign bus.win_valid  = r_win_valid;
  assign bus.line_width = r_line_width;
  assign bus.ovf        = r_ovf;

endmodule
